// File: rtl/mem_lsu_bytelane_if.sv
// EXE-to-MEM request channel and MEM-to-WB result channel of the load/store unit.
// The LSU connects through the slave modport; the upstream/downstream driver uses master.
interface mem_lsu_bytelane_if;
  // request side (EXE -> LSU)
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] req_pc_inc;
  logic        req_reg_write;
  logic [1:0]  req_result_src;
  // result side (LSU -> WB)
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_inc;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_load;
  logic [1:0]  wb_result_src;
  logic [1:0]  wb_err;

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr,
           req_wdata, req_rd, req_pc_inc, req_reg_write, req_result_src, wb_ready,
    output req_ready, wb_valid, wb_read_data, wb_alu_result, wb_pc_inc, wb_rd,
           wb_reg_write, wb_mem_load, wb_result_src, wb_err
  );

  modport master (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr,
           req_wdata, req_rd, req_pc_inc, req_reg_write, req_result_src, wb_ready,
    input  req_ready, wb_valid, wb_read_data, wb_alu_result, wb_pc_inc, wb_rd,
           wb_reg_write, wb_mem_load, wb_result_src, wb_err
  );
endinterface

// File: rtl/mem_lsu_bytelane.sv
// MEM-stage load/store unit: byte-lane data RAM with SB/SH/SW stores, sign/zero
// extending loads, one registered output stage with valid/ready backpressure,
// and fault flagging for bad size/alignment, out-of-range and load+store ops.
// The RAM is four independent byte-wide arrays so each lane has its own write
// enable and registered read port. INIT_FILE is carried for image-loading
// flows; RAM contents start undefined here.
module mem_lsu_bytelane #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter string       INIT_FILE = ""
) (
  input logic               clk,
  input logic               rst_n,
  mem_lsu_bytelane_if.slave bus
);

  localparam int unsigned AW    = $clog2(MEM_BYTES);
  localparam int unsigned DEPTH = MEM_BYTES / 4;
  localparam int unsigned IW    = (AW > 2) ? AW - 2 : 1;

  // Everything the WB stage needs, plus the load shaping info for the registered read.
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] pc_inc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_load;
    logic [1:0]  result_src;
    logic [1:0]  err;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        unsgn;
    logic        ld_ok;
  } wb_t;

  wb_t         wb_q, wb_d;
  logic        req_ready;
  logic        accept;
  logic [31:0] offs;
  logic        in_range;
  logic        misaligned;
  logic [1:0]  req_err;
  logic [IW-1:0] word_idx;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [31:0] rdata_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        unused_init;

  assign unused_init = (INIT_FILE != "");

  // The output register can take a new op when empty or when WB drains it this cycle.
  assign req_ready     = !wb_q.valid || bus.wb_ready;
  assign bus.req_ready = req_ready;
  assign accept        = bus.req_valid && req_ready;

  // Decode the incoming request: RAM index, fault class and store lane steering.
  always_comb begin
    offs       = bus.req_addr - BASE_ADDR;
    in_range   = ((offs >> AW) == 32'd0);
    word_idx   = IW'(offs >> 2);
    misaligned = (bus.req_size == 2'b11) ||
                 ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    req_err    = 2'b00;
    if (bus.req_load || bus.req_store) begin
      if (bus.req_load && bus.req_store) begin
        req_err = 2'b11;
      end else if (misaligned) begin
        req_err = 2'b01;
      end else if (!in_range) begin
        req_err = 2'b10;
      end
    end
    store_be   = 4'b0000;
    store_data = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        store_be   = 4'b0001 << bus.req_addr[1:0];
        store_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << bus.req_addr[1:0];
        store_data = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        store_be   = 4'b1111;
        store_data = bus.req_wdata;
      end
      default: begin
        store_be   = 4'b0000;
        store_data = bus.req_wdata;
      end
    endcase
    // A store presented while reset is held must never reach the array.
    ram_we = accept && bus.req_store && (req_err == 2'b00) && rst_n;
    // Reading only on accept keeps the RAM output frozen through a stall.
    ram_re = accept && bus.req_load;
  end

  // One byte lane per generate iteration: per-lane write enable, registered read.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [DEPTH];
      logic [7:0] rdata_q;

      // Byte-lane RAM write and synchronous read.
      always_ff @(posedge clk) begin
        if (ram_we && store_be[gi]) begin
          ram[word_idx] <= store_data[8*gi +: 8];
        end
        if (ram_re) begin
          rdata_q <= ram[word_idx];
        end
      end

      assign ram_rdata[8*gi +: 8] = rdata_q;
    end
  endgenerate

  // Next state of the output stage: load on accept, drain on wb_ready, else hold.
  always_comb begin
    wb_d = wb_q;
    if (accept) begin
      wb_d.valid      = 1'b1;
      wb_d.alu_result = bus.req_addr;
      wb_d.pc_inc     = bus.req_pc_inc;
      wb_d.rd         = bus.req_rd;
      wb_d.reg_write  = bus.req_reg_write && (req_err == 2'b00);
      wb_d.mem_load   = bus.req_load;
      wb_d.result_src = bus.req_result_src;
      wb_d.err        = req_err;
      wb_d.size       = bus.req_size;
      wb_d.off        = bus.req_addr[1:0];
      wb_d.unsgn      = bus.req_unsigned;
      wb_d.ld_ok      = bus.req_load && (req_err == 2'b00);
    end else if (bus.wb_ready) begin
      wb_d.valid = 1'b0;
    end
  end

  // Output stage register; reset drops any in-flight op and clears all fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // Shape the registered RAM word into the load result using the op's offset/size.
  always_comb begin
    rdata_shift = ram_rdata >> {wb_q.off, 3'b000};
    byte_sel    = rdata_shift[7:0];
    half_sel    = wb_q.off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (wb_q.size)
      2'b00:   load_ext = wb_q.unsgn ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = wb_q.unsgn ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = ram_rdata;
    endcase
  end

  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_read_data  = wb_q.ld_ok ? load_ext : 32'h0;
  assign bus.wb_alu_result = wb_q.alu_result;
  assign bus.wb_pc_inc     = wb_q.pc_inc;
  assign bus.wb_rd         = wb_q.rd;
  assign bus.wb_reg_write  = wb_q.reg_write;
  assign bus.wb_mem_load   = wb_q.mem_load;
  assign bus.wb_result_src = wb_q.result_src;
  assign bus.wb_err        = wb_q.err;

endmodule

// File: tb/tb_mem_lsu_bytelane.sv
// Directed bench for mem_lsu_bytelane: a byte-array reference model tracks what WB
// must see after every edge, a negedge process compares the DUT against it, and the
// main sequence pins the model with hand-computed literals.
module tb_mem_lsu_bytelane;
  localparam int unsigned MEM_BYTES = 16384;
  localparam logic [31:0] BASE      = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_bytelane_if bus ();

  mem_lsu_bytelane #(
    .MEM_BYTES(MEM_BYTES),
    .BASE_ADDR(BASE),
    .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int tag    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mb [MEM_BYTES];
  logic        m_valid;
  logic [31:0] m_rdata, m_alu, m_pc;
  logic [4:0]  m_rd;
  logic        m_rw, m_ld;
  logic [1:0]  m_src, m_err;

  function automatic logic [1:0] model_err(input logic ld, input logic st,
                                           input logic [1:0] sz, input logic [31:0] a);
    longint unsigned addr = a;
    if (!(ld || st)) return 2'd0;
    if (ld && st) return 2'd3;
    if (sz == 2'd3 || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0))
      return 2'd1;
    if (addr < BASE || addr >= longint'(BASE) + MEM_BYTES) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 0; m_rdata = 0; m_alu = 0; m_pc = 0; m_rd = 0;
    m_rw = 0; m_ld = 0; m_src = 0; m_err = 0;
  end

  // Advance the model at each edge from the inputs the bench is presenting.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && (!m_valid || bus.wb_ready)) begin
        int nb;
        int base;
        logic [31:0] v;
        m_err   = model_err(bus.req_load, bus.req_store, bus.req_size, bus.req_addr);
        nb      = 1 << bus.req_size;
        base    = int'(bus.req_addr - BASE);
        v       = 0;
        if (m_err == 0 && bus.req_store)
          for (int i = 0; i < nb; i++) mb[base + i] = 8'(bus.req_wdata >> (8 * i));
        if (m_err == 0 && bus.req_load) begin
          for (int i = 0; i < nb; i++) v = v | (32'(mb[base + i]) << (8 * i));
          if (!bus.req_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        end
        m_valid = 1;
        m_rdata = v;
        m_alu   = bus.req_addr;
        m_pc    = bus.req_pc_inc;
        m_rd    = bus.req_rd;
        m_rw    = bus.req_reg_write && (m_err == 0);
        m_ld    = bus.req_load;
        m_src   = bus.req_result_src;
        $display("op ld=%0b st=%0b size=%0d addr=%h wdata=%h -> err=%0d data=%h",
                 bus.req_load, bus.req_store, bus.req_size, bus.req_addr,
                 bus.req_wdata, m_err, v);
      end else if (bus.wb_ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(bus.wb_valid), 0);
      chk("rst_err", 32'(bus.wb_err), 0);
      chk("rst_rdata", bus.wb_read_data, 0);
    end else begin
      chk("req_ready", 32'(bus.req_ready), 32'(!m_valid || bus.wb_ready));
      chk("wb_valid", 32'(bus.wb_valid), 32'(m_valid));
      if (m_valid) begin
        chk("wb_read_data", bus.wb_read_data, m_rdata);
        chk("wb_alu_result", bus.wb_alu_result, m_alu);
        chk("wb_pc_inc", bus.wb_pc_inc, m_pc);
        chk("wb_rd", 32'(bus.wb_rd), 32'(m_rd));
        chk("wb_reg_write", 32'(bus.wb_reg_write), 32'(m_rw));
        chk("wb_mem_load", 32'(bus.wb_mem_load), 32'(m_ld));
        chk("wb_result_src", 32'(bus.wb_result_src), 32'(m_src));
        chk("wb_err", 32'(bus.wb_err), 32'(m_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    tag++;
    bus.req_valid      = 1;
    bus.req_load       = ld;
    bus.req_store      = st;
    bus.req_size       = sz;
    bus.req_unsigned   = uns;
    bus.req_addr       = addr;
    bus.req_wdata      = wd;
    bus.req_rd         = 5'(tag);
    bus.req_pc_inc     = 32'h1000 + 32'(tag) * 4;
    bus.req_reg_write  = ld;
    bus.req_result_src = ld ? 2'd1 : 2'd0;
  endtask

  // Present an op and return at 1 time unit after the edge that accepted it.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    bit got = 0;
    drive(ld, st, sz, uns, addr, wd);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 32'(got), 1);
    bus.req_valid = 0;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_load = 0; bus.req_store = 0; bus.req_size = 0;
    bus.req_unsigned = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0;
    bus.req_pc_inc = 0; bus.req_reg_write = 0; bus.req_result_src = 0;
    bus.wb_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wb_valid", 32'(bus.wb_valid), 0);
    chk("reset_read_data", bus.wb_read_data, 0);
    rst_n = 1;

    // word store then load: 1-cycle latency
    issue(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF);
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    chk("lw_latency_valid", 32'(bus.wb_valid), 1);
    chk("lw_deadbeef", bus.wb_read_data, 32'hDEADBEEF);
    chk("lw_err", 32'(bus.wb_err), 0);

    // byte stores into a cleared word
    issue(0, 1, 2'd2, 0, 32'h100, 32'h0);
    issue(0, 1, 2'd0, 0, 32'h101, 32'h7F);
    issue(0, 1, 2'd0, 0, 32'h102, 32'h80);
    issue(1, 0, 2'd0, 0, 32'h102, 0);
    chk("lb_sext", bus.wb_read_data, 32'hFFFFFF80);
    issue(1, 0, 2'd0, 1, 32'h102, 0);
    chk("lbu_zext", bus.wb_read_data, 32'h00000080);
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    chk("lw_bytes", bus.wb_read_data, 32'h00807F00);

    // halfword
    issue(0, 1, 2'd1, 0, 32'h206, 32'h1234ABCD);
    issue(1, 0, 2'd1, 0, 32'h206, 0);
    chk("lh_sext", bus.wb_read_data, 32'hFFFFABCD);
    issue(1, 0, 2'd1, 1, 32'h206, 0);
    chk("lhu_zext", bus.wb_read_data, 32'h0000ABCD);
    issue(1, 0, 2'd1, 0, 32'h205, 0);
    chk("lh_mis_err", 32'(bus.wb_err), 1);
    chk("lh_mis_data", bus.wb_read_data, 0);
    chk("lh_mis_rw", 32'(bus.wb_reg_write), 0);

    // range and other faults
    issue(0, 1, 2'd2, 0, 32'h4000, 32'h55555555);
    chk("sw_oor_err", 32'(bus.wb_err), 2);
    issue(0, 1, 2'd2, 0, 32'h4100, 32'h66666666);
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    chk("oor_no_write", bus.wb_read_data, 32'h00807F00);
    issue(0, 1, 2'd2, 0, 32'h3FFC, 32'h0BADF00D);
    issue(1, 0, 2'd2, 0, 32'h3FFC, 0);
    chk("lw_top_word", bus.wb_read_data, 32'h0BADF00D);
    issue(1, 0, 2'd3, 0, 32'h100, 0);
    chk("size3_err", 32'(bus.wb_err), 1);
    issue(1, 1, 2'd2, 0, 32'h100, 32'h77777777);
    chk("ldst_err", 32'(bus.wb_err), 3);
    issue(0, 0, 2'd3, 0, 32'h4003, 0);
    chk("nonmem_err", 32'(bus.wb_err), 0);

    // stall for 3 cycles behind a load, then back-to-back accept
    issue(1, 0, 2'd2, 0, 32'h100, 0);
    bus.wb_ready = 0;
    drive(0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(bus.req_ready), 0);
      chk("stall_rdata", bus.wb_read_data, 32'h00807F00);
      chk("stall_alu", bus.wb_alu_result, 32'h100);
    end
    @(posedge clk);
    #1;
    bus.wb_ready = 1;
    @(negedge clk);
    chk("release_ready", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    chk("b2b_alu", bus.wb_alu_result, 32'h300);
    chk("b2b_valid", 32'(bus.wb_valid), 1);

    // async reset mid-stall with a store pending
    issue(1, 0, 2'd2, 0, 32'h300, 0);
    chk("pre_rst_data", bus.wb_read_data, 32'hCAFEF00D);
    bus.wb_ready = 0;
    drive(0, 1, 2'd2, 0, 32'h300, 32'h11223344);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(bus.wb_valid), 0);
    chk("async_rst_alu", bus.wb_alu_result, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    bus.wb_ready  = 1;
    rst_n = 1;
    issue(1, 0, 2'd2, 0, 32'h300, 0);
    chk("rst_store_dropped", bus.wb_read_data, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
